hdc_sram_fetch_scheduler: RTL

Round-robin scheduler that shares the single item-memory/projection SRAM address bus (`sram_addr`) among the three spatial-encoder modality requesters. It accepts one fetch request at a time and drives the shared address. It strobes the granted modality's three banks (IM, projM_neg, projM_pos), collects their valid returns, and hands a completion back to the requester. It sits between the spatial encoder's per-modality fetch logic and the nine SRAM macros at the `hdc_top` boundary.

---
 rtl/hdc_sram_fetch_scheduler.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/hdc_sram_fetch_scheduler.sv
// Round-robin scheduler sharing one SRAM row-address bus among the modality fetchers.
// Each grant strobes the requester's three banks, gathers their valids and returns a completion.
module hdc_sram_fetch_scheduler #(
    parameter int NUM_REQ    = 3,
    parameter int ADDR_WIDTH = 8,
    parameter int TIMEOUT    = 255
) (
    input  logic                          Clk_CI,
    input  logic                          Reset_RI,
    input  logic [NUM_REQ-1:0]            ReqValid_SI,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] ReqAddr_DI,
    output logic [NUM_REQ-1:0]            ReqReady_SO,
    output logic [ADDR_WIDTH-1:0]         sram_addr,
    output logic [3*NUM_REQ-1:0]          SramReq_SO,
    input  logic [3*NUM_REQ-1:0]          SramValid_SI,
    output logic [NUM_REQ-1:0]            RespValid_SO,
    input  logic [NUM_REQ-1:0]            RespReady_SI,
    output logic                          RespErr_SO,
    output logic                          Busy_SO
);
    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t                state_reg;
    state_t                state_next;
    logic [ADDR_WIDTH-1:0] sram_addr_reg;
    logic [GW-1:0]         grant_reg;
    logic [GW-1:0]         last_grant_reg;
    logic [2:0]            mask_reg;
    logic [CW-1:0]         cnt_reg;
    logic                  err_reg;

    logic [GW-1:0]         arb_idx;
    logic                  arb_found;
    int                    arb_cand;
    logic [NUM_REQ-1:0]    grant_oh;
    logic [NUM_REQ-1:0]    arb_oh;
    logic [3*NUM_REQ-1:0]  grant_banks;
    logic [2:0]            grp_valid [NUM_REQ];
    logic [ADDR_WIDTH-1:0] req_addr [NUM_REQ];
    logic [2:0]            cur_valid;
    logic                  all_valid;
    logic                  timed_out;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_group
        assign grp_valid[gi]          = SramValid_SI[3*gi +: 3];
        assign req_addr[gi]           = ReqAddr_DI[gi*ADDR_WIDTH +: ADDR_WIDTH];
        assign grant_oh[gi]           = (grant_reg == GW'(gi));
        assign arb_oh[gi]             = arb_found && (arb_idx == GW'(gi));
        assign grant_banks[3*gi +: 3] = {3{grant_oh[gi]}};
    end

    // Search starts one past the last served requester so every modality gets a turn.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        arb_cand  = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            arb_cand = int'(last_grant_reg) + k;
            if (arb_cand >= NUM_REQ) begin
                arb_cand = arb_cand - NUM_REQ;
            end
            if (!arb_found && ReqValid_SI[GW'(arb_cand)]) begin
                arb_found = 1'b1;
                arb_idx   = GW'(arb_cand);
            end
        end
    end

    // Only the granted group's returns are observed; foreign banks never reach the mask.
    always_comb begin
        cur_valid = 3'b000;
        for (int g = 0; g < NUM_REQ; g++) begin
            if (grant_oh[g]) begin
                cur_valid = cur_valid | grp_valid[g];
            end
        end
    end

    assign all_valid = &(mask_reg | cur_valid);
    assign timed_out = (cnt_reg == CW'(TIMEOUT - 1));

    always_ff @(posedge Clk_CI or negedge Reset_RI) begin
        if (!Reset_RI) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (arb_found) state_next = ST_ISSUE;
            ST_ISSUE: state_next = all_valid ? ST_RESP : ST_WAIT;
            ST_WAIT:  if (all_valid || timed_out) state_next = ST_RESP;
            ST_RESP:  if ((RespReady_SI & grant_oh) != '0) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk_CI or negedge Reset_RI) begin
        if (!Reset_RI) begin
            sram_addr_reg  <= '0;
            grant_reg      <= '0;
            last_grant_reg <= GW'(NUM_REQ - 1);
            mask_reg       <= '0;
            cnt_reg        <= '0;
            err_reg        <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (arb_found) begin
                        sram_addr_reg <= req_addr[arb_idx];
                        grant_reg     <= arb_idx;
                        mask_reg      <= '0;
                        cnt_reg       <= '0;
                        err_reg       <= 1'b0;
                    end
                end
                ST_ISSUE: begin
                    mask_reg <= mask_reg | cur_valid;
                end
                ST_WAIT: begin
                    mask_reg <= mask_reg | cur_valid;
                    cnt_reg  <= cnt_reg + 1'b1;
                    // A late completion on the final cycle still wins over the timeout.
                    err_reg  <= !all_valid && timed_out;
                end
                ST_RESP: begin
                    if (state_next == ST_IDLE) begin
                        last_grant_reg <= grant_reg;
                    end
                end
                default: ;
            endcase
        end
    end

    // Ready is masked by reset so nothing is accepted while the block is held in reset.
    always_comb begin
        ReqReady_SO  = '0;
        SramReq_SO   = '0;
        RespValid_SO = '0;
        RespErr_SO   = 1'b0;
        Busy_SO      = 1'b1;
        case (state_reg)
            ST_IDLE: begin
                Busy_SO     = 1'b0;
                ReqReady_SO = arb_oh & {NUM_REQ{Reset_RI}};
            end
            ST_ISSUE: SramReq_SO = grant_banks;
            ST_RESP: begin
                RespValid_SO = grant_oh;
                RespErr_SO   = err_reg;
            end
            default: ;
        endcase
    end

    assign sram_addr = sram_addr_reg;

endmodule
